// File: rtl/adder_chk_pkg.sv
// Shared types and constants for the adder response checker.
// Holds the FSM state encoding and counter sizing.
package adder_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_COMPARE
  } chk_state_e;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit saturating result counter.
// Clear wins over increment; the count sticks at all-ones.
module sat_counter16
  import adder_chk_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && count != CNT_MAX) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/adder_response_checker.sv
// Drives a reference sum for an external adder, waits for it to
// settle, then compares its response and keeps pass/fail tallies.
module adder_response_checker
  import adder_chk_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_carry_out,
  input  logic             clr,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             err_sticky,
  output logic [15:0]      pass_count,
  output logic [15:0]      fail_count,
  output logic [WIDTH:0]   expected
);

  chk_state_e state;
  logic [3:0] settle_cnt;
  logic       match;
  logic       cmp_now;
  logic       inc_pass;
  logic       inc_fail;

  assign match    = {dut_carry_out, dut_sum} == expected;
  assign cmp_now  = state == ST_COMPARE;
  assign inc_pass = cmp_now & match;
  assign inc_fail = cmp_now & ~match;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      expected   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            expected <= (WIDTH+1)'(a)
                      + (WIDTH+1)'(b)
                      + (WIDTH+1)'(carry_in);
            settle_cnt <= 4'(SETTLE - 1);
            busy       <= 1'b1;
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == '0) begin
            state <= ST_COMPARE;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        ST_COMPARE: begin
          pass  <= match;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // A failure landing with clr is dropped, matching the counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
    end else if (clr) begin
      err_sticky <= 1'b0;
    end else if (inc_fail) begin
      err_sticky <= 1'b1;
    end
  end

  sat_counter16 u_pass_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (inc_pass),
    .count (pass_count)
  );

  sat_counter16 u_fail_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (inc_fail),
    .count (fail_count)
  );

endmodule

// File: tb/tb_adder_response_checker.sv
// Scoreboard bench: stimulus pushes expected results, a negedge
// monitor pops and compares on every done pulse.
module tb_adder_response_checker;

  localparam int W  = 16;
  localparam int ST = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  a, b;
  logic          cin;
  logic [W-1:0]  dut_sum;
  logic          dut_cout;
  logic          clr;
  logic          busy, done, pass, err_sticky;
  logic [15:0]   pass_count, fail_count;
  logic [W:0]    expected;
  logic [W:0]    fmask;

  int cyc = 0;
  int nchk = 0;
  int nfail = 0;

  typedef struct {
    logic [W:0]  exp;
    logic        ok;
    logic [15:0] pc;
    logic [15:0] fc;
    logic        err;
    int          t_done;
  } item_t;

  item_t q[$];

  logic [15:0] m_pc = '0;
  logic [15:0] m_fc = '0;
  logic        m_err = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural adder under check, with an injectable fault
  always_comb begin
    {dut_cout, dut_sum} = ((W+1)'(a) + (W+1)'(b)
                         + (W+1)'(cin)) ^ fmask;
  end

  adder_response_checker #(.WIDTH(W), .SETTLE(ST)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .a             (a),
    .b             (b),
    .carry_in      (cin),
    .dut_sum       (dut_sum),
    .dut_carry_out (dut_cout),
    .clr           (clr),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_sticky    (err_sticky),
    .pass_count    (pass_count),
    .fail_count    (fail_count),
    .expected      (expected)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        item_t it;
        it = q.pop_front();
        chk("done_cycle", 32'(cyc), 32'(it.t_done));
        chk("pass", 32'(pass), 32'(it.ok));
        chk("expected", 32'(expected), 32'(it.exp));
        chk("pass_count", 32'(pass_count), 32'(it.pc));
        chk("fail_count", 32'(fail_count), 32'(it.fc));
        chk("err_sticky", 32'(err_sticky), 32'(it.err));
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Caller is positioned mid-cycle; start is sampled at next edge
  task automatic run_check(input logic [W-1:0] ia,
                           input logic [W-1:0] ib,
                           input logic ic,
                           input logic [W:0] fault,
                           input bit do_clr,
                           input bit ghost);
    item_t it;
    int unsigned full;
    full = int'(ia) + int'(ib) + int'(ic);
    it.exp = (W+1)'(full);
    it.ok = (fault == '0);
    if (do_clr) begin
      m_pc = '0;
      m_fc = '0;
      m_err = 1'b0;
    end else if (it.ok) begin
      m_pc = sat_inc(m_pc);
    end else begin
      m_fc = sat_inc(m_fc);
      m_err = 1'b1;
    end
    it.pc = m_pc;
    it.fc = m_fc;
    it.err = m_err;
    it.t_done = cyc + 1 + ST + 1;
    q.push_back(it);
    a = ia;
    b = ib;
    cin = ic;
    fmask = fault;
    start = 1'b1;
    @(posedge clk); #1;
    start = ghost;
    if (ghost) begin
      a = W'($urandom);
      b = W'($urandom);
      cin = ~ic;
    end
    repeat (ST - 1) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    a = ia;
    b = ib;
    cin = ic;
    clr = do_clr;
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk); #1;
    chk("pending", 32'(q.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    clr = 1'b0;
    fmask = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_err", 32'(err_sticky), 32'd0);
    chk("rst_pc", 32'(pass_count), 32'd0);
    chk("rst_fc", 32'(fail_count), 32'd0);
    chk("rst_expected", 32'(expected), 32'd0);

    run_check(16'hFFFF, 16'hFFFF, 1'b0, '0, 1'b0, 1'b0);
    run_check(16'hFFFF, 16'hFFFF, 1'b0, 17'h1, 1'b0, 1'b0);
    run_check(16'h1234, 16'h0F0F, 1'b1, '0, 1'b0, 1'b0);
    run_check(16'h8000, 16'h8000, 1'b1, '0, 1'b0, 1'b1);
    run_check(16'h00FF, 16'h0001, 1'b0, 17'h10000, 1'b1, 1'b0);

    @(posedge clk); #1;
    force dut.u_pass_cnt.count = 16'hFFFE;
    @(posedge clk); #1;
    release dut.u_pass_cnt.count;
    m_pc = 16'hFFFE;
    run_check(16'h0001, 16'h0002, 1'b0, '0, 1'b0, 1'b0);
    run_check(16'h4000, 16'h4000, 1'b1, '0, 1'b0, 1'b0);

    @(posedge clk); #1;
    a = 16'h0101;
    b = 16'h0202;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_pc = '0;
    m_fc = '0;
    m_err = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_pc", 32'(pass_count), 32'd0);
    chk("abort_fc", 32'(fail_count), 32'd0);
    chk("abort_err", 32'(err_sticky), 32'd0);
    repeat (ST + 3) @(posedge clk);
    #1;
    run_check(16'hABCD, 16'h1111, 1'b1, '0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [W:0] f;
      f = '0;
      if ($urandom_range(3) == 0)
        f = (W+1)'($urandom_range(1, 17'h1FFFF));
      run_check(W'($urandom), W'($urandom),
                1'($urandom), f,
                ($urandom_range(7) == 0),
                1'($urandom));
    end

    repeat (4) @(posedge clk);
    #1;
    chk("final_queue", 32'(q.size()), 32'd0);
    chk("final_pc", 32'(pass_count), 32'(m_pc));
    chk("final_fc", 32'(fail_count), 32'(m_fc));
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
